// File: rtl/vga_scan_timing.sv
// 640x480@60 raster timing with a 2:1 pixel enable from CLOCK_50, screen-RAM byte to 10-bit RGB mapping.
// Pin outputs reflect the counter state LAT+1 cycles earlier; pixel_data is sampled LAT cycles after its address.
module vga_scan_timing #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int LAT        = 2,
   parameter int COLOR_MODE = 0
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] pixel_data,
   output logic [9:0] x_addr,
   output logic [9:0] y_addr,
   output logic       pix_en,
   output logic       frame_start,
   output logic [9:0] vga_r_DAC,
   output logic [9:0] vga_g_DAC,
   output logic [9:0] vga_b_DAC,
   output logic       vga_clock,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank,
   output logic       vga_sync_dac
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] C_H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] C_V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] C_H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] C_V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] C_HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] C_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] C_VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] C_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic           r_pix_en;
   logic           r_frame_start;
   logic           r_vga_clock;
   logic [9:0]     r_x;
   logic [9:0]     r_y;
   logic [LAT-1:0] r_act_dly;
   logic [LAT-1:0] r_hs_dly;
   logic [LAT-1:0] r_vs_dly;
   logic           r_hs;
   logic           r_vs;
   logic           r_blank;
   logic [9:0]     r_r;
   logic [9:0]     r_g;
   logic [9:0]     r_b;

   logic           w_x_last;
   logic           w_y_last;
   logic           w_active;
   logic           w_hs_raw;
   logic           w_vs_raw;
   logic [9:0]     w_r;
   logic [9:0]     w_g;
   logic [9:0]     w_b;

   assign w_x_last = (r_x == C_H_LAST);
   assign w_y_last = (r_y == C_V_LAST);
   assign w_active = (r_x < C_H_ACT) && (r_y < C_V_ACT);
   assign w_hs_raw = ~((r_x >= C_HS_BEG) && (r_x < C_HS_END));
   assign w_vs_raw = ~((r_y >= C_VS_BEG) && (r_y < C_VS_END));

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_pix_en      <= 1'b0;
         r_vga_clock   <= 1'b0;
         r_frame_start <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
      end else begin
         r_pix_en      <= ~r_pix_en;
         r_vga_clock   <= ~r_pix_en;
         r_frame_start <= r_pix_en && w_x_last && w_y_last;
         if (r_pix_en) begin
            if (w_x_last) begin
               r_x <= '0;
               r_y <= w_y_last ? 10'd0 : r_y + 10'd1;
            end else begin
               r_x <= r_x + 10'd1;
            end
         end
      end
   end

   always_comb begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
      if (COLOR_MODE == 0) begin
         if (pixel_data != 8'd0) begin
            w_r = '1;
            w_g = '1;
            w_b = '1;
         end
      end else begin
         w_r = {pixel_data[7:5], pixel_data[7:5], pixel_data[7:5], pixel_data[7]};
         w_g = {pixel_data[4:2], pixel_data[4:2], pixel_data[4:2], pixel_data[4]};
         w_b = {5{pixel_data[1:0]}};
      end
   end

   // Stage 0 of each delay vector is the newest decode; the cast drops the oldest bit.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         r_act_dly <= '0;
         r_hs_dly  <= '1;
         r_vs_dly  <= '1;
         r_hs      <= 1'b1;
         r_vs      <= 1'b1;
         r_blank   <= 1'b0;
         r_r       <= '0;
         r_g       <= '0;
         r_b       <= '0;
      end else begin
         r_act_dly <= LAT'({r_act_dly, w_active});
         r_hs_dly  <= LAT'({r_hs_dly, w_hs_raw});
         r_vs_dly  <= LAT'({r_vs_dly, w_vs_raw});
         r_hs      <= r_hs_dly[LAT-1];
         r_vs      <= r_vs_dly[LAT-1];
         r_blank   <= r_act_dly[LAT-1];
         r_r       <= r_act_dly[LAT-1] ? w_r : 10'd0;
         r_g       <= r_act_dly[LAT-1] ? w_g : 10'd0;
         r_b       <= r_act_dly[LAT-1] ? w_b : 10'd0;
      end
   end

   assign x_addr       = r_x;
   assign y_addr       = r_y;
   assign pix_en       = r_pix_en;
   assign frame_start  = r_frame_start;
   assign vga_clock    = r_vga_clock;
   assign vga_hs       = r_hs;
   assign vga_vs       = r_vs;
   assign vga_blank    = r_blank;
   assign vga_r_DAC    = r_r;
   assign vga_g_DAC    = r_g;
   assign vga_b_DAC    = r_b;
   assign vga_sync_dac = 1'b0;

endmodule
